// File: rtl/regfile_mp.sv
// Multi-port register file: NRD read ports, two write ports, busy scoreboard.
// Optional REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [1:0]           we,
  input  logic [2*AW-1:0]      wa,
  input  logic [2*WIDTH-1:0]   wd,
  input  logic [NRD*AW-1:0]    ra,
  output logic [NRD*WIDTH-1:0] rd,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 alloc_en,
  input  logic [AW-1:0]        alloc_addr
);

  localparam logic [AW:0] DLIM = (AW+1)'(DEPTH);
  localparam bit          ZR   = (ZERO_REG != 0);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;

  logic [AW-1:0]    wa0, wa1;
  logic [WIDTH-1:0] wd0, wd1;
  logic             wv0, wv1, av;
  logic [AW-1:0]    ra_u [NRD];

  // Out-of-range and hardwired-zero addresses are never stored or tracked.
  function automatic logic ok(input logic [AW-1:0] a);
    return ({1'b0, a} < DLIM) && !(ZR && a == '0);
  endfunction

  assign wa0 = wa[0 +: AW];
  assign wa1 = wa[AW +: AW];
  assign wd0 = wd[0 +: WIDTH];
  assign wd1 = wd[WIDTH +: WIDTH];
  assign wv0 = we[0] && ok(wa0);
  assign wv1 = we[1] && ok(wa1);
  assign av  = alloc_en && ok(alloc_addr);

  for (genvar i = 0; i < NRD; i++) begin : g_ra
    assign ra_u[i] = ra[i*AW +: AW];
  end

  // Later assignments win: port 1 over port 0, alloc over write-clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      regs <= '{default: '0};
      busy <= '0;
    end else begin
      if (wv0) regs[wa0] <= wd0;
      if (wv1) regs[wa1] <= wd1;
      if (wv0) busy[wa0] <= 1'b0;
      if (wv1) busy[wa1] <= 1'b0;
      if (av)  busy[alloc_addr] <= 1'b1;
    end
  end

  always_comb begin
    rd      = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (reset_n && ok(ra_u[i])) begin
        rd[i*WIDTH +: WIDTH] = regs[ra_u[i]];
        rd_busy[i]           = busy[ra_u[i]];
`ifdef REGFILE_BYPASS_EN
        if (wv0 && wa0 == ra_u[i]) begin
          rd[i*WIDTH +: WIDTH] = wd0;
          rd_busy[i]           = 1'b0;
        end
        if (wv1 && wa1 == ra_u[i]) begin
          rd[i*WIDTH +: WIDTH] = wd1;
          rd_busy[i]           = 1'b0;
        end
        if (av && alloc_addr == ra_u[i])
          rd_busy[i] = 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: reset, writes, zero reg, collision,
// scoreboard, optional bypass and mid-cycle reset.
module tb_regfile_mp;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [1:0]  we;
  logic [9:0]  wa;
  logic [63:0] wd;
  logic [9:0]  ra;
  logic [63:0] rd, rd_z;
  logic [1:0]  rd_busy, busy_z;
  logic        alloc_en;
  logic [4:0]  alloc_addr;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  regfile_mp u_dut (
    .clock(clock), .reset_n(reset_n), .we(we), .wa(wa), .wd(wd),
    .ra(ra), .rd(rd), .rd_busy(rd_busy),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr)
  );

  regfile_mp #(.ZERO_REG(0)) u_nz (
    .clock(clock), .reset_n(reset_n), .we(we), .wa(wa), .wd(wd),
    .ra(ra), .rd(rd_z), .rd_busy(busy_z),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    we = 2'b00; alloc_en = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; we = '0; wa = '0; wd = '0; ra = '0;
    alloc_en = 1'b0; alloc_addr = '0;
    #2;
    check("rst_rd0", rd[31:0], 32'h0);
    check("rst_busy", {30'd0, rd_busy}, 32'h0);
    step();
    #2 reset_n = 1'b1;
    step();
    for (int a = 0; a < 32; a++) begin
      ra = {5'(31 - a), 5'(a)};
      #1;
      check("post_rst_rd", rd[31:0] | rd[63:32], 32'h0);
      check("post_rst_busy", {30'd0, rd_busy}, 32'h0);
    end

    we = 2'b01; wa = {5'd0, 5'd1}; wd = {32'h0, 32'hFFFF_FFFF};
    step();
    wa = {5'd0, 5'd2}; wd = {32'h0, 32'hAAAA_AAAA};
    step();
    idle();
    ra = {5'd2, 5'd1};
    #1;
    check("wr_rd0", rd[31:0], 32'hFFFF_FFFF);
    check("wr_rd1", rd[63:32], 32'hAAAA_AAAA);
    ra = {5'd2, 5'd2};
    #1;
    check("same_reg0", rd[31:0], 32'hAAAA_AAAA);
    check("same_reg1", rd[63:32], 32'hAAAA_AAAA);

    we = 2'b01; wa = {5'd0, 5'd0}; wd = {32'h0, 32'hFFFF_FFFF};
    alloc_en = 1'b1; alloc_addr = 5'd0;
    step();
    idle();
    ra = {5'd0, 5'd0};
    #1;
    check("r0_rd", rd[31:0], 32'h0);
    check("r0_busy", {31'd0, rd_busy[0]}, 32'h0);
    check("nz_r0_rd", rd_z[31:0], 32'hFFFF_FFFF);
    check("nz_r0_busy", {31'd0, busy_z[0]}, 32'h1);

    we = 2'b11; wa = {5'd5, 5'd5}; wd = {32'h2222_2222, 32'h1111_1111};
    step();
    idle();
    ra = {5'd0, 5'd5};
    #1;
    check("collide", rd[31:0], 32'h2222_2222);

    alloc_en = 1'b1; alloc_addr = 5'd7;
    step();
    idle();
    ra = {5'd0, 5'd7};
    #1;
    check("alloc_busy", {31'd0, rd_busy[0]}, 32'h1);
    we = 2'b01; wa = {5'd0, 5'd7}; wd = {32'h0, 32'h1234_5678};
    step();
    idle();
    #1;
    check("wr_clr_busy", {31'd0, rd_busy[0]}, 32'h0);
    check("wr_clr_rd", rd[31:0], 32'h1234_5678);
    we = 2'b10; wa = {5'd7, 5'd0}; wd = {32'h0000_BEEF, 32'h0};
    alloc_en = 1'b1; alloc_addr = 5'd7;
    step();
    idle();
    #1;
    check("alloc_wins", {31'd0, rd_busy[0]}, 32'h1);
    check("alloc_wr_rd", rd[31:0], 32'h0000_BEEF);

    ra = {5'd1, 5'd3};
    we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'h0, 32'hABCD_0123};
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_rd", rd[31:0], 32'hABCD_0123);
`else
    check("bypass_rd", rd[31:0], 32'h0);
`endif
    check("bypass_busy", {31'd0, rd_busy[0]}, 32'h0);
    step();
    idle();
    #1;
    check("after_wr3", rd[31:0], 32'hABCD_0123);

    #1 reset_n = 1'b0;
    #1;
    check("midrst_rd0", rd[31:0], 32'h0);
    check("midrst_rd1", rd[63:32], 32'h0);
    check("midrst_nz", rd_z[63:32], 32'h0);
    ra = {5'd0, 5'd7};
    #1;
    check("midrst_busy", {30'd0, rd_busy}, 32'h0);
    we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'h0, 32'h5555_5555};
    step();
    idle();
    reset_n = 1'b1;
    ra = {5'd3, 5'd9};
    #1;
    check("rst_wr_lost", rd[31:0], 32'h0);
    check("rst_kept_clr", rd[63:32], 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
